// File: rtl/csi_rx_lane_align.sv
// Per-lane HS sync-byte hunt at any bit offset, offset lock, and FIFO deskew across lanes.
// Emits one aligned payload byte per lane per cycle once every lane has locked.
module csi_rx_lane_align #(
  parameter int         LANES     = 2,
  parameter logic [3:0] INVERT    = 4'b0000,
  parameter logic [7:0] SYNC_BYTE = 8'hB8,
  parameter int         MAX_SKEW  = 3
) (
  input  logic               byte_clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic [8*LANES-1:0] deser_in_i,
  output logic [8*LANES-1:0] word_out_o,
  output logic               word_valid_o,
  output logic [LANES-1:0]   lane_locked_o,
  output logic               sync_err_o
);

  localparam int DEPTH = MAX_SKEW + 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int SW    = $clog2(MAX_SKEW + 2);

  typedef enum logic { HUNT = 1'b0, LOCKED = 1'b1 } lane_state_e;

  logic [7:0]         din       [LANES];
  logic [7:0]         cur_q     [LANES];
  logic [7:0]         prv_q     [LANES];
  lane_state_e        state_q   [LANES];
  lane_state_e        state_d   [LANES];
  logic [2:0]         off_q     [LANES];
  logic [2:0]         off_d     [LANES];
  logic [7:0]         mem_q     [LANES][DEPTH];
  logic [PW-1:0]      wr_ptr_q  [LANES];
  logic [PW-1:0]      wr_ptr_d  [LANES];
  logic [CW-1:0]      cnt_q     [LANES];
  logic [CW-1:0]      cnt_d     [LANES];
  logic [7:0]         payload   [LANES];
  logic [2:0]         match_off [LANES];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]      skew_q, skew_d;
  logic [8*LANES-1:0] word_q, word_d, rd_dat;
  logic               word_valid_q, word_valid_d;
  logic               sync_err_q, sync_err_d;
  logic [LANES-1:0]   match_vld, locked, locked_nxt, wr_en, nonempty;
  logic               partial, partial_nxt, skew_err, flush, rd_en;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [15:0] win;
    logic        hit;
    logic [2:0]  hit_off;

    assign din[g] = deser_in_i[8*g +: 8] ^ {8{INVERT[g]}};
    assign win    = {cur_q[g], prv_q[g]};

    // Scan from the top so the lowest matching offset is the one left standing.
    always_comb begin
      hit     = 1'b0;
      hit_off = '0;
      for (int k = 7; k >= 0; k--) begin
        if (8'(win >> k) == SYNC_BYTE) begin
          hit     = 1'b1;
          hit_off = 3'(k);
        end
      end
    end

    assign match_vld[g]     = hit;
    assign match_off[g]     = hit_off;
    assign payload[g]       = 8'(win >> off_q[g]);
    assign rd_dat[8*g +: 8] = mem_q[g][rd_ptr_q];
    assign locked[g]        = (state_q[g] == LOCKED);
    assign nonempty[g]      = (cnt_q[g] != '0);
  end

  always_comb begin
    partial  = (|locked) && !(&locked);
    skew_err = enable_i && partial && (skew_q >= SW'(MAX_SKEW));
    flush    = !enable_i || skew_err;
    rd_en    = enable_i && (&locked) && (&nonempty);

    for (int i = 0; i < LANES; i++) begin
      state_d[i]    = state_q[i];
      off_d[i]      = off_q[i];
      wr_en[i]      = !flush && locked[i];
      wr_ptr_d[i]   = wr_ptr_q[i];
      cnt_d[i]      = cnt_q[i] + CW'(wr_en[i]) - CW'(rd_en);
      if (flush) begin
        state_d[i]  = HUNT;
        wr_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end else begin
        if (!locked[i] && match_vld[i]) begin
          state_d[i] = LOCKED;
          off_d[i]   = match_off[i];
        end
        if (wr_en[i]) begin
          wr_ptr_d[i] = (wr_ptr_q[i] == PW'(DEPTH - 1)) ? '0 : wr_ptr_q[i] + 1'b1;
        end
      end
      locked_nxt[i] = (state_d[i] == LOCKED);
    end

    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = '0;
    end else if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    // skew_q holds edges elapsed since the first lane locked while others still hunt.
    partial_nxt = (|locked_nxt) && !(&locked_nxt);
    skew_d      = '0;
    if (!flush && partial && partial_nxt) begin
      skew_d = (skew_q == '1) ? skew_q : skew_q + 1'b1;
    end

    word_d       = rd_en ? rd_dat : word_q;
    word_valid_d = rd_en;
    sync_err_d   = skew_err;
  end

  always_ff @(posedge byte_clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < LANES; i++) begin
        cur_q[i]    <= '0;
        prv_q[i]    <= '0;
        state_q[i]  <= HUNT;
        off_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rd_ptr_q     <= '0;
      skew_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        cur_q[i]    <= din[i];
        prv_q[i]    <= cur_q[i];
        state_q[i]  <= state_d[i];
        off_q[i]    <= off_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rd_ptr_q     <= rd_ptr_d;
      skew_q       <= skew_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  always_ff @(posedge byte_clock_i) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) begin
        mem_q[i][wr_ptr_q[i]] <= payload[i];
      end
    end
  end

  assign word_out_o    = word_q;
  assign word_valid_o  = word_valid_q;
  assign lane_locked_o = locked;
  assign sync_err_o    = sync_err_q;

endmodule

// File: tb/tb_csi_rx_lane_align.sv
// Scoreboard bench: packets are built as per-lane bit streams, expected words and sync
// errors are queued with their due cycle, and a negedge monitor pops and compares them.
module tb_csi_rx_lane_align;

  localparam int         LANES    = 2;
  localparam int         MAX_SKEW = 3;
  localparam logic [3:0] INV      = 4'b0010;
  localparam logic [7:0] SYNC     = 8'hB8;
  localparam logic [15:0] IDLE    = {8'hFF, 8'h00};

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [8*LANES-1:0]   deser;
  logic [8*LANES-1:0]   word_out;
  logic                 word_valid;
  logic [LANES-1:0]     lane_locked;
  logic                 sync_err;

  csi_rx_lane_align #(
    .LANES(LANES), .INVERT(INV), .SYNC_BYTE(SYNC), .MAX_SKEW(MAX_SKEW)
  ) dut (
    .byte_clock_i (clk),
    .reset_i      (reset),
    .enable_i     (enable),
    .deser_in_i   (deser),
    .word_out_o   (word_out),
    .word_valid_o (word_valid),
    .lane_locked_o(lane_locked),
    .sync_err_o   (sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] word;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   errors = 0;
  int   checks = 0;

  // Packet description used by the stream model.
  int         dd[2];
  int         kk[2];
  int         plen_g;
  logic [7:0] pay[2][64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Logical byte m of a lane: d+1 zero bytes, the sync byte, payload, then zeros.
  function automatic logic [7:0] logical(input int ln, input int m);
    if (m <= dd[ln]) return 8'h00;
    if (m == dd[ln] + 1) return SYNC;
    if (m - dd[ln] - 2 < plen_g) return pay[ln][m - dd[ln] - 2];
    return 8'h00;
  endfunction

  // Raw byte j on the wire: the logical bit stream delayed by kk bits, LSB first.
  function automatic logic [7:0] raw(input int ln, input int j);
    logic [7:0] r;
    r = 8'h00;
    for (int q = 0; q < 8; q++) begin
      int b;
      logic [7:0] lb;
      b = 8 * j + q - kk[ln];
      if (b >= 0) begin
        lb   = logical(ln, b / 8);
        r[q] = lb[b % 8];
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (word_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected none (cyc %0d)", word_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word_out", 64'(word_out), 64'(e.word));
        check("word_cycle", 64'(cyc), 64'(e.at));
      end
    end
    if (sync_err === 1'b1) begin
      if (err_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sync_err: got 1 expected 0 (cyc %0d)", cyc);
      end else begin
        int t;
        t = err_q.pop_front();
        check("sync_err_cycle", 64'(cyc), 64'(t));
      end
    end
  end

  // mode: 0 random payload, 1 counting pattern, 2 all zeros, 3 random with 0xB8 inside.
  task automatic run_packet(input int d0, input int d1, input int k0, input int k1,
                            input int plen, input int stop_len, input bit by_reset,
                            input int mode);
    int  c0, maxd, mind;
    bit  is_err;
    dd[0] = d0; dd[1] = d1; kk[0] = k0; kk[1] = k1; plen_g = plen;
    for (int ln = 0; ln < 2; ln++) begin
      for (int n = 0; n < 64; n++) begin
        case (mode)
          1:       pay[ln][n] = 8'(8'h11 * (ln + 1) + 8'h22 * n);
          2:       pay[ln][n] = 8'h00;
          default: pay[ln][n] = 8'($urandom_range(0, 255));
        endcase
      end
      if (mode == 3) begin
        pay[ln][3] = SYNC;
        pay[ln][7] = SYNC;
      end
    end
    maxd   = (d0 > d1) ? d0 : d1;
    mind   = (d0 < d1) ? d0 : d1;
    is_err = (maxd - mind) > MAX_SKEW;
    c0     = cyc;
    if (is_err) begin
      err_q.push_back(c0 + mind + 4 + MAX_SKEW + 1);
    end else begin
      for (int n = 0; maxd + n + 6 <= stop_len; n++) begin
        exp_t e;
        e.word = {logical(1, d1 + 2 + n), logical(0, d0 + 2 + n)};
        e.at   = c0 + maxd + n + 6;
        exp_q.push_back(e);
      end
    end
    for (int j = 0; j < stop_len; j++) begin
      deser  = {raw(1, j) ^ {8{INV[1]}}, raw(0, j) ^ {8{INV[0]}}};
      enable = 1'b1;
      @(negedge clk);
    end
    check("lane_locked_run", 64'(lane_locked), is_err ? 64'h0 : 64'h3);
    if (by_reset) reset = 1'b1;
    else          enable = 1'b0;
    deser = IDLE;
    @(negedge clk);
    check("word_valid_stop", 64'(word_valid), 64'h0);
    check("lane_locked_stop", 64'(lane_locked), 64'h0);
    reset  = 1'b0;
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check("words_pending", 64'(exp_q.size()), 64'h0);
    check("sync_err_pending", 64'(err_q.size()), 64'h0);
    exp_q.delete();
    err_q.delete();
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    deser  = IDLE;
    repeat (3) @(negedge clk);
    check("rst_word_valid", 64'(word_valid), 64'h0);
    check("rst_word_out", 64'(word_out), 64'h0);
    check("rst_lane_locked", 64'(lane_locked), 64'h0);
    check("rst_sync_err", 64'(sync_err), 64'h0);
    reset  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    check("rst_dominates", 64'(lane_locked), 64'h0);
    reset  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);

    run_packet(0, 0, 0, 0, 12, 24, 1'b0, 1);
    run_packet(0, 0, 5, 0, 12, 24, 1'b0, 0);
    run_packet(0, 2, 0, 0, 12, 24, 1'b0, 0);
    run_packet(0, 3, 2, 4, 12, 26, 1'b0, 0);
    run_packet(0, 4, 0, 0, 0, 20, 1'b0, 2);
    run_packet(4, 0, 3, 6, 0, 20, 1'b0, 2);
    run_packet(1, 0, 2, 7, 16, 30, 1'b0, 3);
    run_packet(0, 1, 0, 0, 20, 12, 1'b0, 0);
    run_packet(2, 0, 1, 1, 20, 13, 1'b1, 0);

    for (int r = 0; r < 24; r++) begin
      int d0, d1;
      d0 = $urandom_range(0, 3);
      d1 = $urandom_range(0, 3);
      run_packet(d0, d1, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(1, 30), ((d0 > d1) ? d0 : d1) + 5 + $urandom_range(0, 25),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 3 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
